ps2_scan_rx: RTL

- Receives PS/2 keyboard frames on the two-wire PS/2 interface and decodes them into scan-code events.
- Events carry make/break and extended flags.
- Sits directly upstream of the board-level design: the simulator-driven ps2_clk/ps2_dat lines feed this block, and its event outputs feed user logic that drives the HEX/LEDR displays.
- Runs entirely on CLOCK_50 and oversamples the slow PS/2 clock; no logic is clocked by PS2_CLK.

---
 rtl/ps2_scan_rx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 frame receiver and scan-code decoder, oversampled on CLOCK_50.
// Optional partial-frame timeout is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_scan_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic [7:0] scan_code,
  output logic       is_break,
  output logic       is_extended,
  output logic       code_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   sclk;
  logic                   sdat;
  logic                   sclk_d;
  logic                   fall;

  state_t     state;
  state_t     state_n;
  logic [7:0] shreg;
  logic [7:0] shreg_n;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic       par;
  logic       par_n;
  logic       good;
  logic       bad;
  logic       tmo;
  logic       ext_pend;
  logic       brk_pend;

  // Lines idle high, so the chain resets to 1 to avoid a false edge.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      sclk_d   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
      sclk_d   <= sclk;
    end
  end

  assign sclk = clk_sync[SYNC_STAGES-1];
  assign sdat = dat_sync[SYNC_STAGES-1];
  assign fall = sclk_d & ~sclk;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Fires one cycle early so frame_err lands as the count reaches zero.
  assign tmo_hit = (state != IDLE) && (tmo_cnt <= TW'(1));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      tmo_cnt <= '0;
    end else if (fall) begin
      tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
    end else if (state != IDLE && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end
`endif

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    par_n   = par;
    good    = 1'b0;
    bad     = 1'b0;
    tmo     = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (!sdat) begin
            cnt_n   = 3'd0;
            state_n = DATA;
          end
        end
        DATA: begin
          shreg_n = {sdat, shreg[7:1]};
          cnt_n   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            state_n = PARITY;
          end
        end
        PARITY: begin
          par_n   = sdat;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if ((^shreg ^ par) && sdat) begin
            good = 1'b1;
          end else begin
            bad = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
`ifdef PS2_RX_TIMEOUT_EN
    else if (tmo_hit) begin
      state_n = IDLE;
      tmo     = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      par         <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      frame_err   <= 1'b0;
      scan_code   <= '0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      code_valid  <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      par        <= par_n;
      byte_valid <= good;
      frame_err  <= bad | tmo;
      code_valid <= 1'b0;
      if (good) begin
        byte_data <= shreg;
      end
      // A broken frame poisons any prefix collected so far.
      if (frame_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PFX_EXT) begin
          ext_pend <= 1'b1;
        end else if (byte_data == PFX_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          scan_code   <= byte_data;
          is_break    <= brk_pend;
          is_extended <= ext_pend;
          code_valid  <= 1'b1;
          ext_pend    <= 1'b0;
          brk_pend    <= 1'b0;
        end
      end
    end
  end

endmodule
